// File: rtl/sp_fetch_sched.sv
// sp_fetch_sched: weight-stationary scratchpad fetch scheduler feeding the packing controller
module sp_fetch_sched #(
   parameter int ADDR_W    = 10,
   parameter int DIN_WORDS = 4,
   parameter int WT_WORDS  = 16,
   parameter int TILE_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] wt_base,
   input  logic [ADDR_W-1:0] din_base,
   input  logic [TILE_W-1:0] num_tiles,
   output logic              sp_ren,
   output logic [ADDR_W-1:0] sp_raddr,
   input  logic [63:0]       sp_rdata,
   output logic [63:0]       sp_wt_out,
   output logic              sp_load2,
   output logic [63:0]       sp_din_out,
   output logic              sp_load,
   input  logic              tile_ack,
   output logic [TILE_W-1:0] tile_idx,
   output logic              busy,
   output logic              done
);
   localparam int CW = $clog2(WT_WORDS + 1);
   typedef enum logic [2:0] {IDLE, WT_FETCH, DIN_FETCH, WAIT_ACK, DONE} state_t;
   state_t state, state_n;
   logic phase, phase_n, issue, v1, k1;
   logic [CW-1:0] cnt, cnt_n;
   logic [TILE_W-1:0] tile_n, num_tiles_q;
   logic [ADDR_W-1:0] wt_base_q, din_base_q, addr, raddr_q;
   always_comb begin
      state_n = state;
      phase_n = ~phase;
      cnt_n = cnt;
      tile_n = tile_idx;
      issue = 1'b0;
      addr = (state == WT_FETCH) ? wt_base_q + ADDR_W'(cnt)
           : din_base_q + ADDR_W'(tile_idx) * ADDR_W'(DIN_WORDS) + ADDR_W'(cnt);
      case (state)
         IDLE: begin
            phase_n = 1'b0;
            if (start) begin
               state_n = (num_tiles == '0) ? DONE : WT_FETCH;
               cnt_n = '0;
               tile_n = '0;
            end
         end
         WT_FETCH: begin
            issue = !phase && cnt != CW'(WT_WORDS) && !abort;
            cnt_n = issue ? cnt + 1'b1 : cnt;
            // hold one odd cycle after the last weight read so the read cadence stays 1-in-2
            if (phase && cnt == CW'(WT_WORDS)) begin
               state_n = DIN_FETCH;
               cnt_n = '0;
            end
         end
         DIN_FETCH: begin
            issue = !phase && cnt != CW'(DIN_WORDS) && !abort;
            cnt_n = issue ? cnt + 1'b1 : cnt;
            if (!phase && cnt == CW'(DIN_WORDS)) state_n = WAIT_ACK;
         end
         WAIT_ACK: begin
            phase_n = 1'b0;
            if (tile_ack) begin
               if (tile_idx == num_tiles_q - TILE_W'(1)) state_n = DONE;
               else begin
                  tile_n = tile_idx + 1'b1;
                  cnt_n = '0;
                  state_n = DIN_FETCH;
               end
            end
         end
         DONE: begin
            phase_n = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (abort && state != IDLE) begin
         state_n = IDLE;
         phase_n = 1'b0;
      end
   end
   always_comb begin
      sp_ren = issue;
      sp_raddr = issue ? addr : raddr_q;
      busy = state != IDLE;
      done = state == DONE && !abort;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         phase <= 1'b0;
         cnt <= '0;
         tile_idx <= '0;
         num_tiles_q <= '0;
         wt_base_q <= '0;
         din_base_q <= '0;
         raddr_q <= '0;
         v1 <= 1'b0;
         k1 <= 1'b0;
         sp_load <= 1'b0;
         sp_load2 <= 1'b0;
         sp_wt_out <= '0;
         sp_din_out <= '0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         cnt <= cnt_n;
         tile_idx <= tile_n;
         if (state == IDLE && start) begin
            num_tiles_q <= num_tiles;
            wt_base_q <= wt_base;
            din_base_q <= din_base;
         end
         if (issue) raddr_q <= addr;
         v1 <= issue;
         k1 <= state == WT_FETCH;
         sp_load2 <= v1 && k1 && !abort;
         sp_load <= v1 && !k1 && !abort;
         if (v1 && k1 && !abort) sp_wt_out <= sp_rdata;
         if (v1 && !k1 && !abort) sp_din_out <= sp_rdata;
      end
   end
endmodule

// File: tb/tb_sp_fetch_sched.sv
// tb_sp_fetch_sched: directed checks of fetch order, cadence, handshakes, abort, reset
module tb_sp_fetch_sched;
   logic clk = 0, reset = 1, start = 0, abort = 0, tile_ack = 0;
   logic [9:0] wt_base = 0, din_base = 0, sp_raddr;
   logic [7:0] num_tiles = 0, tile_idx;
   logic [63:0] sp_rdata = 0, sp_wt_out, sp_din_out;
   logic sp_ren, sp_load2, sp_load, busy, done;
   int vectors = 0, miscompares = 0;
   int cyc = 0, gap_err = 0, done_cnt = 0;
   logic pl = 0, pl2 = 0;
   logic [63:0] wt_q[$], din_q[$];
   logic [9:0] ren_a[$];
   int ren_c[$], wt_c[$];

   sp_fetch_sched dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .wt_base(wt_base), .din_base(din_base), .num_tiles(num_tiles),
      .sp_ren(sp_ren), .sp_raddr(sp_raddr), .sp_rdata(sp_rdata),
      .sp_wt_out(sp_wt_out), .sp_load2(sp_load2), .sp_din_out(sp_din_out),
      .sp_load(sp_load), .tile_ack(tile_ack), .tile_idx(tile_idx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] memw(input logic [9:0] a);
      return {22'h2ABCD, a, 22'h155AA, a};
   endfunction

   always @(posedge clk) sp_rdata <= sp_ren ? memw(sp_raddr) : 64'h0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (sp_ren) begin
         ren_a.push_back(sp_raddr);
         ren_c.push_back(cyc);
      end
      if (sp_load2) begin
         wt_q.push_back(sp_wt_out);
         wt_c.push_back(cyc);
      end
      if (sp_load) din_q.push_back(sp_din_out);
      if ((sp_load && pl) || (sp_load2 && pl2)) gap_err <= gap_err + 1;
      if (done) done_cnt <= done_cnt + 1;
      pl <= sp_load;
      pl2 <= sp_load2;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      wt_q.delete(); din_q.delete(); ren_a.delete(); ren_c.delete(); wt_c.delete();
      done_cnt = 0;
      gap_err = 0;
   endtask

   task automatic zero_outputs(input string tag);
      chk({tag, "_ren"}, sp_ren, 0);
      chk({tag, "_raddr"}, sp_raddr, 0);
      chk({tag, "_load2"}, sp_load2, 0);
      chk({tag, "_load"}, sp_load, 0);
      chk({tag, "_wt"}, sp_wt_out, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_tile"}, tile_idx, 0);
   endtask

   initial begin
      tick(3);
      zero_outputs("rst");
      reset = 0;
      tick(2);
      // basic job, with a stray start while busy and an early tile_ack
      clear_logs();
      wt_base = 10'h010; din_base = 10'h040; num_tiles = 2; start = 1;
      tick(1);
      start = 0;
      tick(5);
      start = 1; wt_base = 10'h200; din_base = 10'h300; num_tiles = 5;
      tick(1);
      start = 0;
      for (int i = 0; i < 100 && din_q.size() < 1; i++) tick(1);
      tile_ack = 1;
      tick(1);
      tile_ack = 0;
      tick(20);
      chk("wt_count", wt_q.size(), 16);
      for (int i = 0; i < 16 && i < wt_q.size(); i++) chk("wt_data", wt_q[i], memw(10'(10'h010 + i)));
      chk("din_count0", din_q.size(), 4);
      for (int i = 0; i < 4 && i < din_q.size(); i++) chk("din_data0", din_q[i], memw(10'(10'h040 + i)));
      chk("ren_count0", ren_a.size(), 20);
      for (int i = 0; i < 20 && i < ren_a.size(); i++)
         chk("raddr0", ren_a[i], (i < 16) ? 10'(10'h010 + i) : 10'(10'h040 + i - 16));
      for (int i = 1; i < 20 && i < ren_c.size(); i++) chk("cadence", ren_c[i] - ren_c[i-1], 2);
      if (ren_c.size() > 0 && wt_c.size() > 0) chk("latency", wt_c[0] - ren_c[0], 2);
      else chk("latency_present", 0, 1);
      chk("gap0", gap_err, 0);
      chk("busy_wait", busy, 1);
      chk("tile_wait", tile_idx, 0);
      chk("no_done0", done_cnt, 0);
      tile_ack = 1;
      tick(1);
      tile_ack = 0;
      tick(20);
      chk("din_count1", din_q.size(), 8);
      for (int i = 4; i < 8 && i < din_q.size(); i++) chk("din_data1", din_q[i], memw(10'(10'h040 + i)));
      chk("tile1", tile_idx, 1);
      chk("busy1", busy, 1);
      tile_ack = 1;
      tick(1);
      tile_ack = 0;
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      tick(1);
      chk("done_fall", done, 0);
      chk("busy_fall", busy, 0);
      chk("tile_hold", tile_idx, 1);
      chk("done_once", done_cnt, 1);
      chk("gap1", gap_err, 0);
      // zero tiles: straight to done, no reads
      clear_logs();
      num_tiles = 0; start = 1;
      tick(1);
      start = 0;
      chk("zero_done", done, 1);
      tick(1);
      chk("zero_idle", busy, 0);
      tick(3);
      chk("zero_ren", ren_a.size(), 0);
      chk("zero_done_cnt", done_cnt, 1);
      // address wrap
      clear_logs();
      wt_base = 10'h3F8; din_base = 10'h3FE; num_tiles = 1; start = 1;
      tick(1);
      start = 0;
      tick(50);
      chk("wrap_ren_count", ren_a.size(), 20);
      for (int i = 0; i < 20 && i < ren_a.size(); i++)
         chk("wrap_raddr", ren_a[i], (i < 16) ? 10'(10'h3F8 + i) : 10'(10'h3FE + i - 16));
      chk("wrap_wt8", (wt_q.size() > 8) ? wt_q[8] : 64'h0, memw(10'h000));
      chk("wrap_din2", (din_q.size() > 2) ? din_q[2] : 64'h0, memw(10'h000));
      tile_ack = 1;
      tick(1);
      tile_ack = 0;
      chk("wrap_done", done, 1);
      tick(2);
      // abort in tile 1 fetch
      clear_logs();
      wt_base = 10'h010; din_base = 10'h040; num_tiles = 3; start = 1;
      tick(1);
      start = 0;
      for (int i = 0; i < 100 && din_q.size() < 4; i++) tick(1);
      tick(3);
      tile_ack = 1;
      tick(1);
      tile_ack = 0;
      for (int i = 0; i < 40 && din_q.size() < 5; i++) tick(1);
      abort = 1;
      tick(1);
      abort = 0;
      chk("abort_idle", busy, 0);
      tick(20);
      chk("abort_din_count", din_q.size(), 5);
      chk("abort_din4", (din_q.size() > 4) ? din_q[4] : 64'h0, memw(10'h044));
      chk("abort_no_done", done_cnt, 0);
      // reset mid weight fetch
      wt_base = 10'h010; num_tiles = 2; start = 1;
      tick(1);
      start = 0;
      tick(6);
      chk("pre_reset_busy", busy, 1);
      reset = 1;
      #1;
      zero_outputs("mid_rst");
      clear_logs();
      tick(2);
      reset = 0;
      tick(20);
      chk("post_rst_wt", wt_q.size(), 0);
      chk("post_rst_ren", ren_a.size(), 0);
      chk("post_rst_done", done_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
